// File: rtl/matmul_pkg.sv
// Shared types and helpers for the parametrised matrix multiplier.
package matmul_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MAC   = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_e;

   // Wide enough to hold a full N-term dot product without overflow
   function automatic int unsigned acc_width(input int unsigned dw, input int unsigned n);
      return 2 * dw + $clog2(n);
   endfunction

   function automatic int unsigned elem_off(input int unsigned r, input int unsigned c,
                                            input int unsigned n, input int unsigned dw);
      return (r * n + c) * dw;
   endfunction

endpackage

// File: rtl/matmul_fit.sv
// Fits an ACCW-bit accumulator into DW bits by wrapping or saturating, flagging out-of-range values.
module matmul_fit
   import matmul_pkg::*;
#(
   parameter int unsigned DW     = 8,
   parameter int unsigned ACCW   = 18,
   parameter bit          SIGNED = 1'b0
) (
   input  logic [ACCW-1:0] acc_i,
   input  logic            sat_en,
   output logic [DW-1:0]   val_c,
   output logic            oor_c
);

   always_comb begin
      val_c = acc_i[DW-1:0];
      oor_c = 1'b0;
      if (SIGNED) begin
         // In range only when every bit above the DW sign bit matches it
         oor_c = (acc_i[ACCW-1:DW-1] != {(ACCW-DW+1){acc_i[ACCW-1]}});
         if (sat_en && oor_c) begin
            val_c = acc_i[ACCW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
         end
      end else begin
         oor_c = |acc_i[ACCW-1:DW];
         if (sat_en && oor_c) begin
            val_c = '1;
         end
      end
   end

endmodule

// File: rtl/matmul_param.sv
// Sequential N x N matrix multiplier, C = A*B, using a single iterated MAC.
module matmul_param
   import matmul_pkg::*;
#(
   parameter int unsigned N      = 3,
   parameter int unsigned DW     = 8,
   parameter bit          SIGNED = 1'b0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              sat_en,
   input  logic [N*N*DW-1:0] A_flat,
   input  logic [N*N*DW-1:0] B_flat,
   output logic [N*N*DW-1:0] C_flat,
   output logic              busy,
   output logic              done,
   output logic              overflow
);

   localparam int unsigned ACCW = acc_width(DW, N);
   localparam int unsigned MW   = N * N * DW;
   localparam int unsigned IW   = $clog2(N + 1);
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   state_e          state_q, state_d;
   logic [MW-1:0]   a_q, a_d, b_q, b_d, work_q, work_d, c_q, c_d;
   logic [ACCW-1:0] acc_q, acc_d;
   logic [IW-1:0]   i_q, i_d, j_q, j_d, k_q, k_d;
   logic            sat_q, sat_d, wovf_q, wovf_d, ovf_q, ovf_d;
   logic            busy_q, busy_d, done_q, done_d;

   logic [DW-1:0]   a_el, b_el, fit_val;
   logic [ACCW-1:0] a_ext, b_ext, prod;
   logic            fit_oor;

   // Operand fetch and extension for the current (i,k) x (k,j) product
   always_comb begin
      a_el = a_q[elem_off(32'(i_q), 32'(k_q), N, DW) +: DW];
      b_el = b_q[elem_off(32'(k_q), 32'(j_q), N, DW) +: DW];
      if (SIGNED) begin
         a_ext = {{(ACCW-DW){a_el[DW-1]}}, a_el};
         b_ext = {{(ACCW-DW){b_el[DW-1]}}, b_el};
      end else begin
         a_ext = {{(ACCW-DW){1'b0}}, a_el};
         b_ext = {{(ACCW-DW){1'b0}}, b_el};
      end
      prod = a_ext * b_ext;
   end

   matmul_fit #(
      .DW    (DW),
      .ACCW  (ACCW),
      .SIGNED(SIGNED)
   ) u_fit (
      .acc_i (acc_q),
      .sat_en(sat_q),
      .val_c (fit_val),
      .oor_c (fit_oor)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = MAC;
         MAC:     if (k_q == LAST) state_d = WRITE;
         WRITE:   state_d = (i_q == LAST && j_q == LAST) ? DONE : MAC;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      a_d    = a_q;
      b_d    = b_q;
      sat_d  = sat_q;
      acc_d  = acc_q;
      i_d    = i_q;
      j_d    = j_q;
      k_d    = k_q;
      work_d = work_q;
      wovf_d = wovf_q;
      c_d    = c_q;
      ovf_d  = ovf_q;
      busy_d = busy_q;
      done_d = done_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d    = A_flat;
               b_d    = B_flat;
               sat_d  = sat_en;
               i_d    = '0;
               j_d    = '0;
               k_d    = '0;
               wovf_d = 1'b0;
               busy_d = 1'b1;
            end
         end
         MAC: begin
            acc_d = ((k_q == '0) ? '0 : acc_q) + prod;
            k_d   = k_q + IW'(1);
         end
         WRITE: begin
            work_d[elem_off(32'(i_q), 32'(j_q), N, DW) +: DW] = fit_val;
            wovf_d = wovf_q | fit_oor;
            k_d    = '0;
            if (j_q == LAST) begin
               j_d = '0;
               i_d = i_q + IW'(1);
            end else begin
               j_d = j_q + IW'(1);
            end
            // Publish the whole matrix at once so partial results never appear
            if (i_q == LAST && j_q == LAST) begin
               c_d    = work_d;
               ovf_d  = wovf_q | fit_oor;
               done_d = 1'b1;
               i_d    = '0;
               j_d    = '0;
            end
         end
         DONE: begin
            done_d = 1'b0;
            busy_d = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_q    <= '0;
         b_q    <= '0;
         sat_q  <= 1'b0;
         acc_q  <= '0;
         i_q    <= '0;
         j_q    <= '0;
         k_q    <= '0;
         work_q <= '0;
         wovf_q <= 1'b0;
         c_q    <= '0;
         ovf_q  <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         a_q    <= a_d;
         b_q    <= b_d;
         sat_q  <= sat_d;
         acc_q  <= acc_d;
         i_q    <= i_d;
         j_q    <= j_d;
         k_q    <= k_d;
         work_q <= work_d;
         wovf_q <= wovf_d;
         c_q    <= c_d;
         ovf_q  <= ovf_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign C_flat   = c_q;
   assign overflow = ovf_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_matmul_param.sv
// Bench for matmul_param: unsigned N=3, signed N=3 and unsigned N=4 instances with a result scoreboard.
module tb_matmul_param;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   logic [71:0]  a_u, b_u, c_u, a_s, b_s, c_s;
   logic [127:0] a_4, b_4, c_4;
   logic st_u, st_s, st_4, sat_u, sat_s, sat_4;
   logic bz_u, bz_s, bz_4, dn_u, dn_s, dn_4, ov_u, ov_s, ov_4;

   matmul_param #(.N(3), .DW(8), .SIGNED(1'b0)) dut_u (
      .clk(clk), .reset_n(reset_n), .start(st_u), .sat_en(sat_u), .A_flat(a_u), .B_flat(b_u),
      .C_flat(c_u), .busy(bz_u), .done(dn_u), .overflow(ov_u));
   matmul_param #(.N(3), .DW(8), .SIGNED(1'b1)) dut_s (
      .clk(clk), .reset_n(reset_n), .start(st_s), .sat_en(sat_s), .A_flat(a_s), .B_flat(b_s),
      .C_flat(c_s), .busy(bz_s), .done(dn_s), .overflow(ov_s));
   matmul_param #(.N(4), .DW(8), .SIGNED(1'b0)) dut_4 (
      .clk(clk), .reset_n(reset_n), .start(st_4), .sat_en(sat_4), .A_flat(a_4), .B_flat(b_4),
      .C_flat(c_4), .busy(bz_4), .done(dn_4), .overflow(ov_4));

   typedef struct {
      logic [511:0] c;
      logic         o;
   } exp_t;

   typedef struct {
      string        name;
      int           sel;
      logic [511:0] a;
      logic [511:0] b;
      logic         sat;
      logic [511:0] ec;
      logic         eo;
   } vec_t;

   exp_t sb[$];
   vec_t vt[$];
   int   n_vec = 0;
   int   n_bad = 0;

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [511:0] fill(input int n, input logic [7:0] v);
      logic [511:0] r = '0;
      for (int e = 0; e < n * n; e++) r[e*8 +: 8] = v;
      return r;
   endfunction

   function automatic logic [511:0] ident(input int n);
      logic [511:0] r = '0;
      for (int e = 0; e < n; e++) r[(e*n+e)*8 +: 8] = 8'd1;
      return r;
   endfunction

   function automatic logic [511:0] seq(input int n);
      logic [511:0] r = '0;
      for (int e = 0; e < n * n; e++) r[e*8 +: 8] = 8'(e + 1);
      return r;
   endfunction

   // Reference: integer dot products, then range check and wrap/clamp
   function automatic void model(input int n, input logic [511:0] a, input logic [511:0] b,
                                 input bit sgn, input bit sat,
                                 output logic [511:0] c, output logic ovf);
      longint s, va, vb, lo, hi;
      logic [7:0] x, y, r8;
      c   = '0;
      ovf = 1'b0;
      lo  = sgn ? -128 : 0;
      hi  = sgn ? 127 : 255;
      for (int r = 0; r < n; r++) begin
         for (int cc = 0; cc < n; cc++) begin
            s = 0;
            for (int k = 0; k < n; k++) begin
               x  = a[(r*n+k)*8 +: 8];
               y  = b[(k*n+cc)*8 +: 8];
               va = sgn ? longint'($signed(x)) : longint'(x);
               vb = sgn ? longint'($signed(y)) : longint'(y);
               s  = s + va * vb;
            end
            r8 = s[7:0];
            if (s < lo) begin
               ovf = 1'b1;
               if (sat) r8 = lo[7:0];
            end else if (s > hi) begin
               ovf = 1'b1;
               if (sat) r8 = hi[7:0];
            end
            c[(r*n+cc)*8 +: 8] = r8;
         end
      end
   endfunction

   task automatic drive(input int sel, input logic [511:0] a, input logic [511:0] b,
                        input logic sat, input logic st);
      case (sel)
         0: begin a_u = a[71:0];  b_u = b[71:0];  sat_u = sat; st_u = st; end
         1: begin a_s = a[71:0];  b_s = b[71:0];  sat_s = sat; st_s = st; end
         default: begin a_4 = a[127:0]; b_4 = b[127:0]; sat_4 = sat; st_4 = st; end
      endcase
   endtask

   task automatic sample(input int sel, output logic [511:0] c, output logic d,
                         output logic bz, output logic o);
      c = '0;
      case (sel)
         0: begin c[71:0]  = c_u; d = dn_u; bz = bz_u; o = ov_u; end
         1: begin c[71:0]  = c_s; d = dn_s; bz = bz_s; o = ov_s; end
         default: begin c[127:0] = c_4; d = dn_4; bz = bz_4; o = ov_4; end
      endcase
   endtask

   // One operation; with disturb, inputs are scrambled and start is re-pulsed mid-run and after
   task automatic run_op(input string nm, input int sel, input logic [511:0] a, input logic [511:0] b,
                         input logic sat, input logic [511:0] ec, input logic eo, input bit disturb);
      int n, lat, done_edge, pulses;
      bit busy_gap, busy_late;
      logic [511:0] c;
      logic d, bz, o;
      exp_t ex;
      n         = (sel == 2) ? 4 : 3;
      lat       = n * n * (n + 1);
      done_edge = -1;
      pulses    = 0;
      busy_gap  = 1'b0;
      busy_late = 1'b0;
      ex.c = ec;
      ex.o = eo;
      sb.push_back(ex);
      @(negedge clk);
      drive(sel, a, b, sat, 1'b1);
      @(posedge clk);
      @(negedge clk);
      sample(sel, c, d, bz, o);
      chk({nm, "/busy_rise"}, 512'(bz), 512'(1));
      for (int e = 1; e <= lat + 10; e++) begin
         if (disturb)
            drive(sel, {16{$urandom}}, {16{$urandom}}, ~sat, (e == 5 || e == lat || e == lat + 1));
         else
            drive(sel, a, b, sat, 1'b0);
         @(posedge clk);
         @(negedge clk);
         sample(sel, c, d, bz, o);
         if (d) begin
            pulses++;
            if (done_edge < 0) begin
               done_edge = e;
               if (sb.size() > 0) begin
                  ex = sb.pop_front();
                  chk({nm, "/C_flat"}, c, ex.c);
                  chk({nm, "/overflow"}, 512'(o), 512'(ex.o));
               end
            end
         end
         if (e <= lat && !bz) busy_gap = 1'b1;
         if (e > lat && bz) busy_late = 1'b1;
      end
      if (done_edge < 0 && sb.size() > 0) void'(sb.pop_front());
      chk({nm, "/done_edge"}, 512'(done_edge), 512'(lat));
      chk({nm, "/done_pulses"}, 512'(pulses), 512'(1));
      chk({nm, "/busy_gap"}, 512'(busy_gap), 512'(0));
      chk({nm, "/busy_late"}, 512'(busy_late), 512'(0));
      drive(sel, a, b, sat, 1'b0);
   endtask

   function automatic vec_t mk(input string nm, input int sel, input logic [511:0] a,
                               input logic [511:0] b, input logic sat,
                               input logic [511:0] ec, input logic eo);
      vec_t v;
      v.name = nm; v.sel = sel; v.a = a; v.b = b; v.sat = sat; v.ec = ec; v.eo = eo;
      return v;
   endfunction

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [511:0] c, ra, rb, ec;
      logic d, bz, o, eo, rs;
      int sel;

      vt.push_back(mk("ident",      0, ident(3),       seq(3),          1'b0, seq(3),          1'b0));
      vt.push_back(mk("wrap",       0, fill(3, 8'hFF), fill(3, 8'hFF),  1'b0, fill(3, 8'h03),  1'b1));
      vt.push_back(mk("sat",        0, fill(3, 8'hFF), fill(3, 8'hFF),  1'b1, fill(3, 8'hFF),  1'b1));
      vt.push_back(mk("u_edge255",  0, fill(3, 8'h01), fill(3, 8'h55),  1'b1, fill(3, 8'hFF),  1'b0));
      vt.push_back(mk("s_sat_neg",  1, fill(3, 8'h80), fill(3, 8'h7F),  1'b1, fill(3, 8'h80),  1'b1));
      vt.push_back(mk("s_ident",    1, fill(3, 8'hFF), ident(3),        1'b1, fill(3, 8'hFF),  1'b0));
      vt.push_back(mk("s_sat_pos",  1, fill(3, 8'h7F), fill(3, 8'h7F),  1'b1, fill(3, 8'h7F),  1'b1));
      vt.push_back(mk("s_wrap_neg", 1, fill(3, 8'h81), fill(3, 8'h02),  1'b0, fill(3, 8'h06),  1'b1));
      vt.push_back(mk("s_clmp_neg", 1, fill(3, 8'h81), fill(3, 8'h02),  1'b1, fill(3, 8'h80),  1'b1));
      vt.push_back(mk("n4_ones",    2, fill(4, 8'h01), fill(4, 8'h01),  1'b0, fill(4, 8'h04),  1'b0));

      reset_n = 1'b0;
      for (int s = 0; s < 3; s++) drive(s, '0, '0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         sample(s, c, d, bz, o);
         chk($sformatf("reset%0d/C_flat", s), c, '0);
         chk($sformatf("reset%0d/flags", s), 512'({d, bz, o}), '0);
      end
      reset_n = 1'b1;

      foreach (vt[v])
         run_op(vt[v].name, vt[v].sel, vt[v].a, vt[v].b, vt[v].sat, vt[v].ec, vt[v].eo, 1'b0);

      for (int r = 0; r < 6; r++) begin
         sel = (r < 5) ? (r % 2) : 2;
         ra  = {16{$urandom}};
         rb  = {16{$urandom}};
         rs  = 1'($urandom_range(0, 1));
         model((sel == 2) ? 4 : 3, ra, rb, sel == 1, rs, ec, eo);
         run_op($sformatf("rand%0d", r), sel, ra, rb, rs, ec, eo, 1'b0);
      end

      // Operands and start toggled while running must not disturb the captured operation
      run_op("hs_capture", 0, fill(3, 8'hFF), fill(3, 8'hFF), 1'b0, fill(3, 8'h03), 1'b1, 1'b1);

      // Asynchronous reset mid-operation clears everything immediately
      @(negedge clk);
      drive(0, seq(3), seq(3), 1'b0, 1'b1);
      @(posedge clk);
      @(negedge clk);
      drive(0, seq(3), seq(3), 1'b0, 1'b0);
      repeat (9) @(posedge clk);
      @(posedge clk);
      #1 reset_n = 1'b0;
      #1 sample(0, c, d, bz, o);
      chk("rst_mid/C_flat", c, '0);
      chk("rst_mid/flags", 512'({d, bz, o}), '0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      sample(0, c, d, bz, o);
      chk("rst_idle/flags", 512'({d, bz, o}), '0);
      model(3, seq(3), seq(3), 1'b0, 1'b0, ec, eo);
      run_op("post_reset", 0, seq(3), seq(3), 1'b0, ec, eo, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
